dpb_seq: RTL and testbench

DPB_SEQ -- requirements
Module: dpb_seq

---
 rtl/dpb_seq.sv | 139 +++++++++++++
 tb/tb_dpb_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dpb_seq.sv
// dpb_seq: fills a 32-word RAM with SEED+addr, verifies it through a read-latency
// tag pipeline, then slowly scans the contents onto six LEDs.
module dpb_seq #(
    parameter int          READ_LAT = 2,
    parameter logic [31:0] SEED     = 32'hA5A5_0000,
    parameter int          DIV      = 13_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ce,
    output logic        oce,
    output logic        wre,
    output logic        ram_reset,
    output logic [4:0]  ad,
    output logic [31:0] din,
    input  logic [31:0] dout,
    output logic [5:0]  leds,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, FILL, VERIFY, DRAIN, SCAN, FAIL} state_t;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = 5 * READ_LAT;

    state_t                state_q, state_d;
    logic                  ce_q, ce_d, oce_q, oce_d, wre_q, wre_d;
    logic                  done_q, done_d, err_q, err_d;
    logic [4:0]            ad_q, ad_d, fail_addr_q, fail_addr_d;
    logic [31:0]           din_q, din_d;
    logic [5:0]            leds_q, leds_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [READ_LAT-1:0]   vld_q, vld_d;
    logic [TW-1:0]         tag_q, tag_d;
    logic [4:0]            rtag;
    logic                  rvld, miss;

    // Every read issued (ce without wre) carries its address down the pipeline
    // so the response can be matched when it emerges READ_LAT cycles later.
    always_comb begin
        state_d     = state_q;
        ce_d        = 1'b0;
        wre_d       = 1'b0;
        ad_d        = ad_q;
        din_d       = din_q;
        leds_d      = leds_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        presc_d     = presc_q;
        vld_d       = READ_LAT'({vld_q, ce_q & ~wre_q});
        tag_d       = TW'({tag_q, ad_q});
        rtag        = tag_q[TW-1 -: 5];
        rvld        = vld_q[READ_LAT-1];
        miss        = rvld && (dout != SEED + {27'd0, rtag});
        case (state_q)
            IDLE: begin
                state_d = FILL;
                ce_d    = 1'b1;
                wre_d   = 1'b1;
                ad_d    = 5'd0;
                din_d   = SEED;
            end
            FILL: begin
                state_d = (ad_q == 5'd31) ? VERIFY : FILL;
                ce_d    = 1'b1;
                wre_d   = (ad_q != 5'd31);
                ad_d    = ad_q + 5'd1;
                din_d   = din_q + 32'd1;
            end
            VERIFY, DRAIN: begin
                if (miss) begin
                    state_d     = FAIL;
                    err_d       = 1'b1;
                    fail_addr_d = rtag;
                    leds_d      = {1'b1, rtag};
                end else if (state_q == VERIFY) begin
                    state_d = (ad_q == 5'd31) ? DRAIN : VERIFY;
                    ce_d    = (ad_q != 5'd31);
                    ad_d    = (ad_q == 5'd31) ? ad_q : ad_q + 5'd1;
                end else if (rvld && rtag == 5'd31) begin
                    state_d = SCAN;
                    ce_d    = 1'b1;
                    ad_d    = 5'd0;
                    presc_d = '0;
                end
            end
            SCAN: begin
                leds_d  = rvld ? dout[5:0] : leds_q;
                presc_d = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + 1'b1;
                ce_d    = (presc_q == PW'(DIV - 1));
                ad_d    = (presc_q == PW'(DIV - 1)) ? ad_q + 5'd1 : ad_q;
            end
            default: state_d = FAIL;
        endcase
        oce_d  = (state_d == VERIFY) || (state_d == DRAIN) || (state_d == SCAN);
        done_d = (state_d == SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ce_q        <= 1'b0;
            oce_q       <= 1'b0;
            wre_q       <= 1'b0;
            ad_q        <= 5'd0;
            din_q       <= 32'd0;
            leds_q      <= 6'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            fail_addr_q <= 5'd0;
            presc_q     <= '0;
            vld_q       <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            ce_q        <= ce_d;
            oce_q       <= oce_d;
            wre_q       <= wre_d;
            ad_q        <= ad_d;
            din_q       <= din_d;
            leds_q      <= leds_d;
            done_q      <= done_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            presc_q     <= presc_d;
            vld_q       <= vld_d;
            tag_q       <= tag_d;
        end
    end

    assign ce        = ce_q;
    assign oce       = oce_q;
    assign wre       = wre_q;
    assign ram_reset = 1'b0;
    assign ad        = ad_q;
    assign din       = din_q;
    assign leds      = leds_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_dpb_seq.sv
// tb_dpb_seq: directed bench for dpb_seq with behavioural RAMs at read latency 2 and 1.
module tb_dpb_seq;
    logic        clk = 1'b0, rst_n = 1'b0, corrupt = 1'b0;
    logic        ce0, oce0, wre0, rr0, done0, err0;
    logic        ce1, oce1, wre1, rr1, done1, err1;
    logic [4:0]  ad0, ad1;
    logic [31:0] din0, din1, dout0, dout1, r0a, r0b, r1a;
    logic [5:0]  leds0, leds1;
    logic [31:0] mem0 [32];
    logic [31:0] mem1 [32];
    int          checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;

    dpb_seq #(.READ_LAT(2), .SEED(32'hA5A5_0000), .DIV(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .ce(ce0), .oce(oce0), .wre(wre0), .ram_reset(rr0),
        .ad(ad0), .din(din0), .dout(dout0), .leds(leds0), .done(done0), .err(err0));

    dpb_seq #(.READ_LAT(1), .SEED(32'hA5A5_0000), .DIV(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce1), .oce(oce1), .wre(wre1), .ram_reset(rr1),
        .ad(ad1), .din(din1), .dout(dout1), .leds(leds1), .done(done1), .err(err1));

    always @(posedge clk) begin
        if (ce0 && wre0) mem0[ad0] <= din0;
        if (ce0 && !wre0) r0a <= mem0[ad0] ^ ((corrupt && ad0 == 5'd7) ? 32'h1 : 32'h0);
        r0b <= r0a;
        if (ce1 && wre1) mem1[ad1] <= din1;
        if (ce1 && !wre1) r1a <= mem1[ad1];
    end
    assign dout0 = r0b;
    assign dout1 = r1a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(negedge clk);
            cyc++;
            chk("inv_wre_fill", 32'(!wre0 || u_dut.state_q == 3'd1), 32'd1);
            chk("inv_done_err", 32'(done0 && err0), 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ce"}, 32'(ce0), 32'd0);
        chk({tag, "_oce"}, 32'(oce0), 32'd0);
        chk({tag, "_wre"}, 32'(wre0), 32'd0);
        chk({tag, "_ram_reset"}, 32'(rr0), 32'd0);
        chk({tag, "_ad"}, 32'(ad0), 32'd0);
        chk({tag, "_din"}, din0, 32'd0);
        chk({tag, "_leds"}, 32'(leds0), 32'd0);
        chk({tag, "_done"}, 32'(done0), 32'd0);
        chk({tag, "_err"}, 32'(err0), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        chk("idle_ce", 32'(ce0), 32'd0);
        goto(1);
        chk("fill0_ce", 32'(ce0), 32'd1);
        chk("fill0_wre", 32'(wre0), 32'd1);
        chk("fill0_ad", 32'(ad0), 32'd0);
        chk("fill0_din", din0, 32'hA5A5_0000);
        chk("fill0_oce", 32'(oce0), 32'd0);
        goto(2);
        chk("fill1_din", din0, 32'hA5A5_0001);
        goto(32);
        chk("fill31_ad", 32'(ad0), 32'd31);
        chk("fill31_din", din0, 32'hA5A5_001F);
        chk("fill31_wre", 32'(wre0), 32'd1);
        goto(33);
        chk("ver0_ce", 32'(ce0), 32'd1);
        chk("ver0_wre", 32'(wre0), 32'd0);
        chk("ver0_ad", 32'(ad0), 32'd0);
        chk("ver0_oce", 32'(oce0), 32'd1);
        goto(65);
        chk("l1_done_early", 32'(done1), 32'd0);
        goto(66);
        chk("l2_done_early", 32'(done0), 32'd0);
        chk("l1_done", 32'(done1), 32'd1);
        chk("l1_err", 32'(err1), 32'd0);
        chk("l1_scan_ce", 32'(ce1), 32'd1);
        chk("l1_scan_ad", 32'(ad1), 32'd0);
        goto(67);
        chk("l2_done", 32'(done0), 32'd1);
        chk("l2_err", 32'(err0), 32'd0);
        for (int k = 0; k <= 32; k++) begin
            goto(67 + 8 * k);
            chk("scan_ce", 32'(ce0), 32'd1);
            chk("scan_ad", 32'(ad0), 32'(k % 32));
            goto(68 + 8 * k);
            chk("scan_idle_ce", 32'(ce0), 32'd0);
            goto(70 + 8 * k);
            chk("scan_leds", 32'(leds0), 32'(k % 32));
        end

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        goto(45);
        chk("ver12_ad", 32'(ad0), 32'd12);
        chk("ver12_ce", 32'(ce0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        goto(1);
        chk("refill_ad", 32'(ad0), 32'd0);
        chk("refill_wre", 32'(wre0), 32'd1);
        chk("refill_din", din0, 32'hA5A5_0000);
        goto(67);
        chk("redo_done", 32'(done0), 32'd1);
        chk("redo_err", 32'(err0), 32'd0);

        rst_n = 1'b0;
        corrupt = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        goto(42);
        chk("bad_pre_err", 32'(err0), 32'd0);
        chk("bad_pre_ce", 32'(ce0), 32'd1);
        goto(43);
        chk("bad_err", 32'(err0), 32'd1);
        chk("bad_leds", 32'(leds0), 32'h27);
        chk("bad_ce", 32'(ce0), 32'd0);
        chk("bad_oce", 32'(oce0), 32'd0);
        goto(150);
        chk("bad_late_err", 32'(err0), 32'd1);
        chk("bad_late_done", 32'(done0), 32'd0);
        chk("bad_late_ce", 32'(ce0), 32'd0);
        chk("bad_late_leds", 32'(leds0), 32'h27);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
